// File: rtl/cnn_pe_pkg.sv
// Shared CNN PE types and default sizing for the IFMAP scratchpad datapath.
// Pure declarations: no logic, no latency, no flow control.
package cnn_pe_pkg;

  localparam int CONFIG_BIT_DEF = 4;
  localparam int NUM_OF_REG_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int OCC_WIDTH_DEF  = CONFIG_BIT_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ifmap_spad_writer_if.sv
// IFMAP writer bundle: upstream stream, scratchpad write port, reader release and status.
// master drives the stream/release/config side; slave is the writer itself.
interface ifmap_spad_writer_if #(
  parameter int CONFIG_BIT = cnn_pe_pkg::CONFIG_BIT_DEF,
  parameter int DATA_WIDTH = cnn_pe_pkg::DATA_WIDTH_DEF
);

  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  logic                  wr_en;
  logic [CONFIG_BIT-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rel_valid;
  logic [CONFIG_BIT-1:0] rel_count;
  logic [CONFIG_BIT:0]   win_size;

  logic                  win_ready;
  logic [CONFIG_BIT:0]   occupancy;
  logic                  full;
  logic                  empty;
  logic                  done;
  logic                  err_underflow;

  modport master (
    output start, in_valid, in_data, in_last, rel_valid, rel_count, win_size,
    input  in_ready, wr_en, wr_addr, wr_data, win_ready, occupancy, full, empty,
           done, err_underflow
  );

  modport slave (
    input  start, in_valid, in_data, in_last, rel_valid, rel_count, win_size,
    output in_ready, wr_en, wr_addr, wr_data, win_ready, occupancy, full, empty,
           done, err_underflow
  );

endinterface

// File: rtl/ifmap_occ_counter.sv
// Scratchpad occupancy up/down counter: +1 per accept, -rel_count per release, clamps at 0.
// Registered result, one cycle after the edge; underflow flag is sticky until clr or reset.
module ifmap_occ_counter #(
  parameter int CONFIG_BIT = cnn_pe_pkg::CONFIG_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  rel_valid,
  input  logic [CONFIG_BIT-1:0] rel_count,
  output logic [CONFIG_BIT:0]   occupancy,
  output logic                  err_underflow
);

  localparam int SW = CONFIG_BIT + 2;

  logic [SW-1:0]        rel_amt;
  logic signed [SW-1:0] occ_next;

  // One extra sign bit so an over-release shows up as a negative result.
  always_comb begin
    rel_amt  = rel_valid ? {2'b00, rel_count} : '0;
    occ_next = $signed({1'b0, occupancy}) + $signed(SW'(inc)) - $signed(rel_amt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy     <= '0;
      err_underflow <= 1'b0;
    end else if (clr) begin
      occupancy     <= '0;
      err_underflow <= 1'b0;
    end else if (occ_next < 0) begin
      occupancy     <= '0;
      err_underflow <= 1'b1;
    end else begin
      occupancy     <= occ_next[CONFIG_BIT:0];
    end
  end

endmodule

// File: rtl/ifmap_spad_writer.sv
// IFMAP scratchpad fill: writes accepted elements into a circular register file, zero-latency write.
// in_ready = RUN && !full (independent of in_valid); window/full/empty flags lag one cycle.
module ifmap_spad_writer
  import cnn_pe_pkg::*;
#(
  parameter int CONFIG_BIT = CONFIG_BIT_DEF,
  parameter int NUM_OF_REG = NUM_OF_REG_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  ifmap_spad_writer_if.slave  bus
);

  localparam int OW = CONFIG_BIT + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(NUM_OF_REG);

  state_t                state;
  state_t                state_nxt;
  logic [CONFIG_BIT-1:0] wr_ptr;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         win_eff;
  logic                  err;
  logic                  done_q;
  logic                  in_rdy;
  logic                  clr;
  logic                  accept;
  logic                  full_w;
  logic                  empty_w;

  assign full_w  = (occ == FULL_OCC);
  assign empty_w = (occ == '0);
  assign accept  = bus.in_valid && in_rdy;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          clr       = 1'b1;
        end
      end
      RUN: begin
        in_rdy = !full_w;
        if (bus.in_valid && !full_w && bus.in_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (empty_w) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DRAIN) && empty_w;
      if (clr) begin
        wr_ptr <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + CONFIG_BIT'(1);
      end
    end
  end

  ifmap_occ_counter #(
    .CONFIG_BIT (CONFIG_BIT)
  ) u_occ (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .inc           (accept),
    .rel_valid     (bus.rel_valid),
    .rel_count     (bus.rel_count),
    .occupancy     (occ),
    .err_underflow (err)
  );

  // A zero window would otherwise read as permanently ready.
  assign win_eff = (bus.win_size == '0) ? OW'(1) : bus.win_size;

  assign bus.in_ready      = in_rdy;
  assign bus.wr_en         = accept;
  assign bus.wr_addr       = wr_ptr;
  assign bus.wr_data       = bus.in_data;
  assign bus.occupancy     = occ;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.win_ready     = (state != IDLE) && (occ >= win_eff);
  assign bus.done          = done_q;
  assign bus.err_underflow = err;

endmodule

// File: tb/tb_ifmap_spad_writer.sv
// Self-checking bench for ifmap_spad_writer against an integer occupancy/pointer model.
module tb_ifmap_spad_writer;

  localparam int CB = 4;
  localparam int NR = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 filling, 2 draining.
  int m_occ, m_ptr, m_mode;
  bit m_err, m_done;

  ifmap_spad_writer_if #(.CONFIG_BIT(CB), .DATA_WIDTH(DW)) bus();

  ifmap_spad_writer #(.CONFIG_BIT(CB), .NUM_OF_REG(NR), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return (m_mode == 1) && (m_occ < NR);
  endfunction

  function automatic bit exp_win();
    int w;
    w = (bus.win_size == 0) ? 1 : int'(bus.win_size);
    return (m_mode != 0) && (m_occ >= w);
  endfunction

  task automatic model_reset();
    m_occ = 0; m_ptr = 0; m_mode = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_tick();
    bit acc;
    int rel, n;
    acc = bus.in_valid && exp_ready();
    rel = bus.rel_valid ? int'(bus.rel_count) : 0;
    m_done = 0;
    if (m_mode == 0 && bus.start) begin
      m_mode = 1; m_occ = 0; m_ptr = 0; m_err = 0;
    end else begin
      if (m_mode == 1 && acc && bus.in_last) m_mode = 2;
      else if (m_mode == 2 && m_occ == 0) begin m_mode = 0; m_done = 1; end
      n = m_occ + (acc ? 1 : 0) - rel;
      if (n < 0) begin n = 0; m_err = 1; end
      m_occ = n;
      m_ptr = (m_ptr + (acc ? 1 : 0)) % NR;
    end
  endtask

  task automatic drive(input bit st, input bit v, input logic [7:0] d, input bit l,
                       input bit rv, input int rc);
    @(negedge clk);
    bus.start = st; bus.in_valid = v; bus.in_data = d; bus.in_last = l;
    bus.rel_valid = rv; bus.rel_count = CB'(rc);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
    bus.rel_valid = 0; bus.rel_count = '0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_pass();
    drive(1, 0, 8'h00, 0, 0, 0);
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic test_reset();
    bus.win_size = 5'd9;
    do_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL reset_win_ready got %b want 0", bus.win_ready); end
    checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    checks++; if (bus.done !== 1'b0 || bus.err_underflow !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b want 00", bus.done, bus.err_underflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_window();
    logic [7:0] d;
    do_reset();
    bus.win_size = 5'd9;
    start_pass();
    checks++; if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL fill_win_early got %b want 0", bus.win_ready); end
    for (int i = 0; i < 9; i++) begin
      d = 8'(8'h10 + i);
      drive(0, 1, d, 0, 0, 0);
      checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== CB'(i) || bus.wr_data !== d) begin
        errors++; $display("FAIL fill_write en=%b addr=%0d data=%h want 1 %0d %h", bus.wr_en, bus.wr_addr, bus.wr_data, i, d);
      end
      advance();
      checks++; if (bus.occupancy !== 5'(i + 1)) begin errors++; $display("FAIL fill_occ got %0d want %0d", bus.occupancy, i + 1); end
      checks++; if (bus.win_ready !== (i + 1 >= 9)) begin errors++; $display("FAIL fill_win got %b want %b", bus.win_ready, (i + 1 >= 9)); end
    end
  endtask

  task automatic test_full_wrap();
    int n_acc;
    bit ea;
    do_reset();
    start_pass();
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'($urandom), 0, 0, 0);
      ea = exp_ready();
      checks++; if (bus.wr_en !== ea || bus.in_ready !== ea) begin
        errors++; $display("FAIL full_stream cyc %0d wr_en=%b in_ready=%b want %b", i, bus.wr_en, bus.in_ready, ea);
      end
      if (bus.wr_en === 1'b1) n_acc++;
      advance();
    end
    checks++; if (n_acc != 16) begin errors++; $display("FAIL full_accepts got %0d want 16", n_acc); end
    checks++; if (bus.full !== 1'b1 || bus.occupancy !== 5'd16) begin errors++; $display("FAIL full_flag full=%b occ=%0d want 1 16", bus.full, bus.occupancy); end
    drive(0, 0, 8'h00, 0, 1, 3);
    advance();
    checks++; if (bus.occupancy !== 5'd13 || bus.full !== 1'b0) begin errors++; $display("FAIL full_release occ=%0d full=%b want 13 0", bus.occupancy, bus.full); end
    drive(0, 1, 8'hA5, 0, 0, 0);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd0) begin errors++; $display("FAIL full_wrap en=%b addr=%0d want 1 0", bus.wr_en, bus.wr_addr); end
    advance();
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_pass();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 8'($urandom), 0, 0, 0);
      advance();
    end
    checks++; if (bus.occupancy !== 5'd10) begin errors++; $display("FAIL simul_pre got %0d want 10", bus.occupancy); end
    drive(0, 1, 8'h3C, 0, 1, 2);
    advance();
    checks++; if (bus.occupancy !== 5'd9) begin errors++; $display("FAIL simul_occ got %0d want 9", bus.occupancy); end
  endtask

  task automatic test_underflow();
    do_reset();
    start_pass();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 8'($urandom), 0, 0, 0);
      advance();
    end
    drive(0, 0, 8'h00, 0, 1, 5);
    advance();
    checks++; if (bus.occupancy !== 5'd0 || bus.empty !== 1'b1 || bus.err_underflow !== 1'b1) begin
      errors++; $display("FAIL under_flag occ=%0d empty=%b err=%b want 0 1 1", bus.occupancy, bus.empty, bus.err_underflow);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 0, 0, 0);
      advance();
      checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL under_sticky got %b want 1", bus.err_underflow); end
    end
    drive(0, 1, 8'h77, 1, 0, 0);
    advance();
    drive(0, 0, 8'h00, 0, 1, 1);
    advance();
    drive(0, 0, 8'h00, 0, 0, 0);
    advance();
    checks++; if (bus.err_underflow !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL under_idle err=%b rdy=%b want 1 0", bus.err_underflow, bus.in_ready); end
    start_pass();
    checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL under_clear got %b want 0", bus.err_underflow); end
  endtask

  task automatic test_drain_done();
    int done_cnt;
    do_reset();
    start_pass();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'($urandom), (i == 3), 0, 0);
      advance();
    end
    checks++; if (bus.occupancy !== 5'd4) begin errors++; $display("FAIL drain_occ got %0d want 4", bus.occupancy); end
    drive(0, 1, 8'h55, 0, 0, 0);
    checks++; if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL drain_block rdy=%b en=%b want 0 0", bus.in_ready, bus.wr_en); end
    drive(0, 0, 8'h00, 0, 1, 4);
    advance();
    checks++; if (bus.occupancy !== 5'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL drain_empty occ=%0d done=%b want 0 0", bus.occupancy, bus.done); end
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 0, 0, 0);
      advance();
      checks++; if (bus.done !== m_done) begin errors++; $display("FAIL drain_done cyc %0d got %b want %b", i, bus.done, m_done); end
      if (bus.done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL drain_done_count got %0d want 1", done_cnt); end
    checks++; if (bus.win_ready !== 1'b0) begin errors++; $display("FAIL drain_idle_win got %b want 0", bus.win_ready); end
  endtask

  task automatic test_start_ignored_and_reset_mid();
    do_reset();
    start_pass();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'($urandom), 0, 0, 0);
      advance();
    end
    drive(1, 1, 8'h99, 0, 0, 0);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'd5) begin errors++; $display("FAIL run_start en=%b addr=%0d want 1 5", bus.wr_en, bus.wr_addr); end
    advance();
    drive(0, 1, 8'h9A, 0, 0, 0);
    advance();
    checks++; if (bus.occupancy !== 5'd7) begin errors++; $display("FAIL run_start_occ got %0d want 7", bus.occupancy); end
    drive(0, 1, 8'h9B, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.occupancy !== 5'd0 || bus.wr_en !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset occ=%0d en=%b rdy=%b want 0 0 0", bus.occupancy, bus.wr_en, bus.in_ready);
    end
    checks++; if (bus.empty !== 1'b1 || bus.win_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags empty=%b win=%b want 1 0", bus.empty, bus.win_ready); end
    model_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit ea;
    do_reset();
    bus.win_size = 5'($urandom_range(0, 16));
    start_pass();
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 49) bus.win_size = 5'($urandom_range(0, 16));
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            (c >= 100 && $urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 5));
      ea = exp_ready();
      checks++; if (bus.in_ready !== ea || bus.wr_en !== (ea && bus.in_valid)) begin
        errors++; $display("FAIL rnd_hs cyc %0d rdy=%b en=%b want %b %b", c, bus.in_ready, bus.wr_en, ea, ea && bus.in_valid);
      end
      if (ea && bus.in_valid) begin
        checks++; if (bus.wr_addr !== CB'(m_ptr) || bus.wr_data !== bus.in_data) begin
          errors++; $display("FAIL rnd_wr cyc %0d addr=%0d want %0d", c, bus.wr_addr, m_ptr);
        end
      end
      advance();
      checks++; if (bus.occupancy !== 5'(m_occ) || bus.full !== (m_occ == NR) || bus.empty !== (m_occ == 0)) begin
        errors++; $display("FAIL rnd_occ cyc %0d occ=%0d full=%b empty=%b want %0d", c, bus.occupancy, bus.full, bus.empty, m_occ);
      end
      checks++; if (bus.win_ready !== exp_win() || bus.done !== m_done || bus.err_underflow !== m_err) begin
        errors++; $display("FAIL rnd_flags cyc %0d win=%b done=%b err=%b want %b %b %b", c, bus.win_ready, bus.done, bus.err_underflow, exp_win(), m_done, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    bus.win_size = 5'd9;
    test_reset();
    test_fill_window();
    test_full_wrap();
    test_simultaneous();
    test_underflow();
    test_drain_done();
    test_start_ignored_and_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
